// File: rtl/tx_ab_commit_arb.sv
// tx_ab_commit_arb
//   Packet-level arbiter that merges two AFU TX AXI-S streams (A: writes and
//   other TLPs, B: reads and interrupts) onto one FIM TX stream. It also emits
//   a write-commit completion on the C stream for every memory write that
//   completes on A.
//
// Ports
//   clk, rst             : single rising-edge clock, async active-high reset
//   a_t* / a_tready      : TX A stream in, ready out
//   b_t* / b_tready      : TX B stream in, ready out
//   o_t* / o_tready      : merged TX stream out, ready in (zero-latency mux)
//   c_t* / c_tready      : write-commit stream out, ready in
//   commit_cnt           : commit FIFO occupancy

// Guards the commit FIFO against overflow.
module tx_ab_commit_arb_chk #(
    parameter int COMMIT_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] cnt
);
    // Only A pushes, and a write is admitted only while the FIFO has room.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt == CNT_W'(COMMIT_DEPTH))));
endmodule

module tx_ab_commit_arb #(
    parameter int TDATA_W      = 512,
    parameter int TUSER_W      = 10,
    parameter int COMMIT_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            a_tvalid,
    input  logic [TDATA_W-1:0]              a_tdata,
    input  logic [TDATA_W/8-1:0]            a_tkeep,
    input  logic                            a_tlast,
    input  logic [TUSER_W-1:0]              a_tuser,
    output logic                            a_tready,
    input  logic                            b_tvalid,
    input  logic [TDATA_W-1:0]              b_tdata,
    input  logic [TDATA_W/8-1:0]            b_tkeep,
    input  logic                            b_tlast,
    input  logic [TUSER_W-1:0]              b_tuser,
    output logic                            b_tready,
    output logic                            o_tvalid,
    output logic [TDATA_W-1:0]              o_tdata,
    output logic [TDATA_W/8-1:0]            o_tkeep,
    output logic                            o_tlast,
    output logic [TUSER_W-1:0]              o_tuser,
    input  logic                            o_tready,
    output logic                            c_tvalid,
    output logic [TDATA_W-1:0]              c_tdata,
    output logic [TDATA_W/8-1:0]            c_tkeep,
    output logic                            c_tlast,
    output logic [TUSER_W-1:0]              c_tuser,
    input  logic                            c_tready,
    output logic [$clog2(COMMIT_DEPTH):0]   commit_cnt
);
    localparam int KEEP_W   = TDATA_W / 8;
    localparam int PTR_W    = $clog2(COMMIT_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int CPL_KEEP = (KEEP_W < 32) ? KEEP_W : 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    // Memory write: fmt bit30 set and type field [28:24] all zero.
    function automatic logic is_mem_wr(input logic [7:0] fmt_type);
        return fmt_type[6] & (fmt_type[4:0] == 5'b00000);
    endfunction

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             wr_q, wr_d;
    logic [7:0]       tag_q, tag_d;
    logic [7:0]       mem_q [COMMIT_DEPTH];
    logic [7:0]       mem_d [COMMIT_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       fifo_full_s, a_head_wr_s, elig_a_s, elig_b_s;
    logic       sel_a_s, sel_b_s, hs_s, push_s, pop_s, push_wr_s;
    logic [7:0] push_tag_s;

    // Source selection: eligibility in IDLE, held ownership while locked.
    always_comb begin
        fifo_full_s = (cnt_q == CNT_W'(COMMIT_DEPTH));
        a_head_wr_s = is_mem_wr(a_tdata[31:24]);
        // A write is only admitted at SOP when its commit is sure to fit.
        elig_a_s    = a_tvalid & ~(a_head_wr_s & fifo_full_s);
        elig_b_s    = b_tvalid;
        sel_a_s     = 1'b0;
        sel_b_s     = 1'b0;
        if (rst) begin
            sel_a_s = 1'b0;
            sel_b_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (elig_a_s && elig_b_s) begin
                        sel_a_s = ~rr_q;
                        sel_b_s = rr_q;
                    end else begin
                        sel_a_s = elig_a_s;
                        sel_b_s = elig_b_s;
                    end
                end
                LOCK_A:  sel_a_s = 1'b1;
                LOCK_B:  sel_b_s = 1'b1;
                default: begin
                    sel_a_s = 1'b0;
                    sel_b_s = 1'b0;
                end
            endcase
        end
    end

    // Zero-latency pass-through of the selected source.
    always_comb begin
        o_tvalid = 1'b0;
        o_tdata  = '0;
        o_tkeep  = '0;
        o_tlast  = 1'b0;
        o_tuser  = '0;
        a_tready = 1'b0;
        b_tready = 1'b0;
        if (sel_a_s) begin
            o_tvalid = a_tvalid;
            o_tdata  = a_tdata;
            o_tkeep  = a_tkeep;
            o_tlast  = a_tlast;
            o_tuser  = a_tuser;
            a_tready = o_tready;
        end else if (sel_b_s) begin
            o_tvalid = b_tvalid;
            o_tdata  = b_tdata;
            o_tkeep  = b_tkeep;
            o_tlast  = b_tlast;
            o_tuser  = b_tuser;
            b_tready = o_tready;
        end else begin
            o_tvalid = 1'b0;
        end
    end

    // Arbiter next state, SOP write/tag capture and commit push decision.
    always_comb begin
        hs_s    = o_tvalid & o_tready;
        state_d = state_q;
        rr_d    = rr_q;
        wr_d    = wr_q;
        tag_d   = tag_q;
        // In IDLE the beat on A is its SOP, so use it directly (single-beat writes).
        if (state_q == IDLE) begin
            push_wr_s  = a_head_wr_s;
            push_tag_s = a_tdata[47:40];
        end else begin
            push_wr_s  = wr_q;
            push_tag_s = tag_q;
        end
        if (hs_s) begin
            if (sel_a_s && (state_q == IDLE)) begin
                wr_d  = a_head_wr_s;
                tag_d = a_tdata[47:40];
            end else begin
                wr_d  = wr_q;
                tag_d = tag_q;
            end
            if (o_tlast) begin
                state_d = IDLE;
                rr_d    = sel_a_s;
            end else begin
                state_d = sel_a_s ? LOCK_A : LOCK_B;
                rr_d    = rr_q;
            end
        end else begin
            state_d = state_q;
        end
        push_s = hs_s & sel_a_s & a_tlast & push_wr_s;
    end

    // Commit FIFO: tag storage, wrapping pointers and occupancy.
    always_comb begin
        pop_s  = c_tvalid & c_tready;
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_s) begin
            mem_d[wptr_q] = push_tag_s;
            wptr_d        = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Commit beat built from the FIFO head; valid only from registered occupancy.
    always_comb begin
        c_tvalid        = (cnt_q != '0);
        c_tdata         = '0;
        c_tdata[31:24]  = 8'h0A;
        c_tdata[47:40]  = mem_q[rptr_q];
        c_tkeep         = '0;
        for (int i = 0; i < CPL_KEEP; i++) begin
            c_tkeep[i] = 1'b1;
        end
        c_tlast         = 1'b1;
        c_tuser         = '0;
        commit_cnt      = cnt_q;
    end

    // State registers; reset abandons any packet and drops pending commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            wr_q    <= 1'b0;
            tag_q   <= 8'h00;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < COMMIT_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            tag_q   <= tag_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < COMMIT_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    tx_ab_commit_arb_chk #(
        .COMMIT_DEPTH (COMMIT_DEPTH),
        .CNT_W        (CNT_W)
    ) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .cnt  (cnt_q)
    );
endmodule

// File: tb/tb_tx_ab_commit_arb.sv
module tb_tx_ab_commit_arb;
    localparam int TDATA_W = 512;
    localparam int TUSER_W = 10;
    localparam int DEPTH   = 4;
    localparam int KW      = TDATA_W / 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_tvalid, b_tvalid, o_tvalid, c_tvalid;
    logic [TDATA_W-1:0] a_tdata, b_tdata, o_tdata, c_tdata;
    logic [KW-1:0]      a_tkeep, b_tkeep, o_tkeep, c_tkeep;
    logic               a_tlast, b_tlast, o_tlast, c_tlast;
    logic [TUSER_W-1:0] a_tuser, b_tuser, o_tuser, c_tuser;
    logic               a_tready, b_tready, o_tready, c_tready;
    logic [CW-1:0]      commit_cnt;

    tx_ab_commit_arb #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W), .COMMIT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_tvalid(a_tvalid), .a_tdata(a_tdata), .a_tkeep(a_tkeep), .a_tlast(a_tlast),
        .a_tuser(a_tuser), .a_tready(a_tready),
        .b_tvalid(b_tvalid), .b_tdata(b_tdata), .b_tkeep(b_tkeep), .b_tlast(b_tlast),
        .b_tuser(b_tuser), .b_tready(b_tready),
        .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast),
        .o_tuser(o_tuser), .o_tready(o_tready),
        .c_tvalid(c_tvalid), .c_tdata(c_tdata), .c_tkeep(c_tkeep), .c_tlast(c_tlast),
        .c_tuser(c_tuser), .c_tready(c_tready), .commit_cnt(commit_cnt)
    );

    // Source packet queues and per-source beat driver state (index 0 = A, 1 = B).
    typedef struct packed {
        logic [7:0] typ;
        logic [7:0] tag;
        logic [2:0] len;
    } pkt_t;

    pkt_t pq0[$];
    pkt_t pq1[$];
    logic               s_valid [2];
    logic [TDATA_W-1:0] s_data  [2];
    logic [KW-1:0]      s_keep  [2];
    logic               s_last  [2];
    logic [TUSER_W-1:0] s_user  [2];
    int                 beat    [2];
    logic               acc     [2];
    bit                 rand_mode;

    assign a_tvalid = s_valid[0];
    assign a_tdata  = s_data[0];
    assign a_tkeep  = s_keep[0];
    assign a_tlast  = s_last[0];
    assign a_tuser  = s_user[0];
    assign b_tvalid = s_valid[1];
    assign b_tdata  = s_data[1];
    assign b_tkeep  = s_keep[1];
    assign b_tlast  = s_last[1];
    assign b_tuser  = s_user[1];

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [TDATA_W-1:0] act, logic [TDATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: owner (0 none, 1 A, 2 B), round-robin pointer, commit tag queue.
    int         m_owner;
    bit         m_rr;
    logic [7:0] m_q[$];
    bit         m_wr;
    logic [7:0] m_tag;
    int         served[$];
    logic [7:0] popped[$];
    int         n_push;

    function automatic bit is_wr(logic [7:0] t);
        return t[6] && (t[4:0] == 5'd0);
    endfunction

    function automatic logic [31:0] served_code();
        logic [31:0] v = 32'h0;
        for (int i = 0; i < served.size() && i < 8; i++) v = v | (32'(served[i]) << (4 * i));
        return v;
    endfunction

    function automatic logic [31:0] popped_code();
        logic [31:0] v = 32'h0;
        for (int i = 0; i < popped.size() && i < 8; i++) v = v | (32'(popped[i][3:0]) << (4 * i));
        return v;
    endfunction

    // Per-cycle compare against the model, then model advance for the coming edge.
    always @(negedge clk) begin : cmp
        int                 sel;
        bit                 ea, eb, ev, hs, last, wr, push;
        logic [7:0]         tg;
        logic [TDATA_W-1:0] cexp;
        logic [KW-1:0]      kexp;
        if (rst) begin
            chk("rst_o_tvalid", o_tvalid, 0);
            chk("rst_a_tready", a_tready, 0);
            chk("rst_b_tready", b_tready, 0);
            chk("rst_c_tvalid", c_tvalid, 0);
            chk("rst_commit_cnt", commit_cnt, 0);
            m_owner = 0; m_rr = 1'b0; m_q.delete();
            acc[0] = 1'b0; acc[1] = 1'b0;
        end else begin
            if (m_owner == 0) begin
                ea  = a_tvalid && !(is_wr(a_tdata[31:24]) && m_q.size() == DEPTH);
                eb  = b_tvalid;
                sel = (ea && eb) ? (m_rr ? 2 : 1) : (ea ? 1 : (eb ? 2 : 0));
            end else begin
                sel = m_owner;
            end
            ev = (sel == 1) ? a_tvalid : ((sel == 2) ? b_tvalid : 1'b0);
            chk("o_tvalid", o_tvalid, ev);
            chk("a_tready", a_tready, (sel == 1) && o_tready);
            chk("b_tready", b_tready, (sel == 2) && o_tready);
            if (ev) begin
                chk("o_tdata", o_tdata, (sel == 1) ? a_tdata : b_tdata);
                chk("o_tkeep", o_tkeep, (sel == 1) ? a_tkeep : b_tkeep);
                chk("o_tlast", o_tlast, (sel == 1) ? a_tlast : b_tlast);
                chk("o_tuser", o_tuser, (sel == 1) ? a_tuser : b_tuser);
            end
            chk("commit_cnt", commit_cnt, m_q.size());
            chk("c_tvalid", c_tvalid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                cexp = '0; cexp[31:24] = 8'h0A; cexp[47:40] = m_q[0];
                kexp = '0; kexp[31:0] = 32'hFFFF_FFFF;
                chk("c_tdata", c_tdata, cexp);
                chk("c_tkeep", c_tkeep, kexp);
                chk("c_tlast", c_tlast, 1'b1);
                chk("c_tuser", c_tuser, 0);
            end
            hs     = ev && o_tready;
            acc[0] = hs && (sel == 1);
            acc[1] = hs && (sel == 2);
            push   = 1'b0;
            tg     = 8'h00;
            if (hs) begin
                served.push_back(sel);
                last = (sel == 1) ? a_tlast : b_tlast;
                if (sel == 1) begin
                    wr = (m_owner == 0) ? is_wr(a_tdata[31:24]) : m_wr;
                    tg = (m_owner == 0) ? a_tdata[47:40] : m_tag;
                    m_wr = wr; m_tag = tg;
                    push = last && wr;
                end
                if (last) begin m_owner = 0; m_rr = (sel == 1); end
                else m_owner = sel;
            end
            if (m_q.size() > 0 && c_tready) popped.push_back(m_q.pop_front());
            if (push) begin m_q.push_back(tg); n_push++; end
        end
    end

    function automatic int qsize(int s);
        return (s == 0) ? pq0.size() : pq1.size();
    endfunction

    function automatic pkt_t qhead(int s);
        if (s == 0) return pq0[0];
        else return pq1[0];
    endfunction

    task automatic qpop(int s);
        pkt_t d;
        if (s == 0) d = pq0.pop_front();
        else d = pq1.pop_front();
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        case ($urandom_range(0, 5))
            0: p.typ = 8'h40;
            1: p.typ = 8'h60;
            2: p.typ = 8'h00;
            3: p.typ = 8'h4A;
            4: p.typ = 8'h20;
            default: p.typ = 8'h30;
        endcase
        p.tag = 8'($urandom);
        p.len = 3'($urandom_range(1, 4));
        return p;
    endfunction

    // Advance accepted beats, present the next beat, and randomise readies in random mode.
    task automatic drive();
        pkt_t p;
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
                s_valid[s] = 1'b0;
                beat[s]++;
                if (beat[s] == int'(qhead(s).len)) begin qpop(s); beat[s] = 0; end
            end
            if (!s_valid[s] && qsize(s) > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                p = qhead(s);
                for (int w = 0; w < TDATA_W / 32; w++) s_data[s][w*32 +: 32] = $urandom;
                if (beat[s] == 0) begin s_data[s][31:24] = p.typ; s_data[s][47:40] = p.tag; end
                s_keep[s]  = {$urandom, $urandom};
                s_last[s]  = (beat[s] == int'(p.len) - 1);
                s_user[s]  = TUSER_W'($urandom);
                s_valid[s] = 1'b1;
            end
        end
        if (rand_mode) begin
            o_tready = ($urandom_range(0, 3) != 0);
            c_tready = ($urandom_range(0, 2) == 0);
            if (pq0.size() < 2) pq0.push_back(rand_pkt());
            if (pq1.size() < 2) pq1.push_back(rand_pkt());
        end
    endtask

    task automatic run(int n);
        repeat (n) begin @(posedge clk); #1; drive(); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pq0.delete(); pq1.delete();
        for (int s = 0; s < 2; s++) begin
            s_valid[s] = 1'b0; s_data[s] = '0; s_keep[s] = '0;
            s_last[s] = 1'b0; s_user[s] = '0; beat[s] = 0;
        end
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        served.delete(); popped.delete(); n_push = 0;
    endtask

    function automatic pkt_t mk(logic [7:0] typ, logic [7:0] tag, int len);
        pkt_t p;
        p.typ = typ; p.tag = tag; p.len = 3'(len);
        return p;
    endfunction

    initial begin
        int g;
        rst = 1'b1; rand_mode = 1'b0; o_tready = 1'b1; c_tready = 1'b1;
        acc[0] = 1'b0; acc[1] = 1'b0;

        // Continuous one-beat reads on both sides alternate A,B,... starting with A.
        do_reset();
        for (int i = 0; i < 6; i++) begin pq0.push_back(mk(8'h00, 8'h10, 1)); pq1.push_back(mk(8'h00, 8'h20, 1)); end
        run(7); #2;
        chk("alt_order", served_code(), 32'h0021_2121);
        chk("alt_no_commit", n_push, 0);

        // Four-beat write tag 35 on A runs contiguously before B's read, then commits.
        do_reset();
        c_tready = 1'b0;
        pq0.push_back(mk(8'h40, 8'h35, 4)); pq1.push_back(mk(8'h00, 8'h01, 1));
        run(6); #2;
        chk("wr4_order", served_code(), 32'h0002_1111);
        chk("wr4_cnt", commit_cnt, 1);
        chk("wr4_cpl_type", c_tdata[31:24], 8'h0A);
        chk("wr4_cpl_tag", c_tdata[47:40], 8'h35);

        // B owns the output through o_tready stalls until its last beat.
        do_reset();
        c_tready = 1'b1; o_tready = 1'b1;
        pq1.push_back(mk(8'h00, 8'h02, 3));
        run(1);
        pq0.push_back(mk(8'h00, 8'h03, 1));
        for (int i = 0; i < 8; i++) begin run(1); o_tready = (i % 2 == 1); end
        o_tready = 1'b1; #2;
        chk("lock_b_order", served_code(), 32'h0000_1222);

        // Full commit FIFO stalls A's next write while B passes; one pop releases it.
        do_reset();
        c_tready = 1'b0; o_tready = 1'b1;
        for (int t = 1; t <= 4; t++) pq0.push_back(mk(8'h40, 8'(t), 1));
        run(5); #2;
        chk("full_cnt", commit_cnt, 4);
        pq0.push_back(mk(8'h40, 8'h05, 1)); pq1.push_back(mk(8'h00, 8'h06, 1));
        served.delete();
        run(4); #2;
        chk("full_a_valid", a_tvalid, 1);
        chk("full_a_stall", a_tready, 0);
        chk("full_b_pass", served_code(), 32'h0000_0002);
        chk("full_head_tag", c_tdata[47:40], 8'h01);
        c_tready = 1'b1;
        run(1);
        c_tready = 1'b0;
        run(3); #2;
        chk("refill_cnt", commit_cnt, 4);
        chk("refill_order", served_code(), 32'h0000_0012);
        chk("first_pop", popped_code(), 32'h0000_0001);
        c_tready = 1'b1;
        run(6); #2;
        chk("drain_order", popped_code(), 32'h0005_4321);
        chk("drain_cnt", commit_cnt, 0);

        // Reset in the middle of a four-beat write abandons it.
        do_reset();
        pq0.push_back(mk(8'h40, 8'h77, 4));
        g = 0;
        while (served.size() < 2 && g < 20) begin run(1); g++; end
        chk("mid_wr_reached", served.size() >= 2, 1);
        do_reset();
        #2;
        chk("post_rst_cnt", commit_cnt, 0);
        chk("post_rst_c_tvalid", c_tvalid, 0);
        pq0.push_back(mk(8'h00, 8'h08, 1)); pq1.push_back(mk(8'h00, 8'h09, 1));
        run(3); #2;
        chk("post_rst_order", served_code(), 32'h0000_0021);

        // Randomised traffic with a reset in the middle.
        rand_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            run(1);
        end
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
